pattern_generator: RTL and testbench
====================================

// Module: pattern_generator
// PURPOSE
//   Run-length-encoded bit-stream source that drives the X input of the pattern
//   predictor. Software/bench loads a table of (value, length) runs, then pulses
//   start. The block emits one bit per clock on X, with X_valid, and counts emitted bits.
//   It can replay the table once or loop continuously. Transmit-side counterpart to the predictor.
// PARAMETERS
//   DEPTH   8   number of run-table entries (power of 2, >=2)
//   LEN_W   8   run-length field width; a run lasts (len+1) cycles
//   CNT_W   8   width of X_cnt emitted-bit counter
// PORTS
//   clk        in   1              rising-edge clock
//   reset      in   1              synchronous, active-high reset
//   wr_en      in   1              write one run-table entry (ignored while busy)
//   wr_addr    in   $clog2(DEPTH)  entry index
//   wr_val     in   1              bit value for the run
//   wr_len     in   LEN_W          run length minus one
//   num_runs   in   $clog2(DEPTH)+1  active entries 0..DEPTH; sampled at start
//   loop       in   1              1: wrap to entry 0 after last run; sampled at start
//   start      in   1              begin emission (honoured in IDLE/DONE only)
//   abort      in   1              stop emission, return to IDLE
//   X          out  1              emitted bit
//   X_valid    out  1              X carries a pattern bit this cycle
//   X_cnt      out  CNT_W          bits emitted since last start, saturating
//   busy       out  1              high in RUN
//   done       out  1              high in DONE (non-loop pattern finished)
// BEHAVIOUR
//   Reset: state=IDLE; X=0, X_valid=0, X_cnt=0, busy=0, done=0; run index=0,
//     run counter=0; table contents NOT cleared.
//   All outputs registered. FSM states IDLE, RUN, DONE.
//   IDLE/DONE + start & num_runs!=0 -> RUN; latch num_runs/loop; idx=0;
//     X_cnt=0; done=0. First bit (entry 0) on X with X_valid=1 in the cycle
//     after the edge sampling start (1-cycle latency).
//   start with num_runs==0: ignored, state unchanged.
//   RUN: X=table[idx].val, X_valid=1 for (len+1) consecutive cycles per entry;
//     no bubbles between runs or across loop wrap.
//   After last cycle of entry num_runs-1: loop=1 -> idx=0, stay RUN;
//     loop=0 -> DONE next cycle: X_valid=0, X=0, busy=0, done=1 (held).
//   X_cnt increments on every X_valid cycle; saturates at 2^CNT_W-1, no wrap.
//   abort (any state) -> IDLE next cycle: X_valid=0, X=0, busy=0, done=0;
//     X_cnt holds value. abort has priority over start in same cycle.
//   wr_en while busy: write dropped. wr_en in IDLE/DONE writes at the edge;
//     write and start same cycle: write takes effect, and is visible to emission.
//   start while RUN: ignored (no restart).
//   reset mid-RUN: outputs return to reset values next edge; table retained.
//   wr_addr >= num_runs entries are never emitted.
// TESTING
//   1 Load 7 runs (0,3)(1,7)(0,3)(1,3)(0,7)(1,3)(0,3), loop=0, start -> X =
//     000011111111000011110000000011110000, X_valid 36 cycles, X_cnt=36, done=1.
//   2 Same table, loop=1 -> 72 contiguous valid bits, pattern repeats exactly,
//     no gap at wrap; done stays 0, busy stays 1.
//   3 loop=1, run 300 cycles with CNT_W=8 -> X_cnt sticks at 255.
//   4 abort at bit 10 of scenario 1 -> next cycle X_valid=0, busy=0, done=0,
//     X_cnt=10; subsequent start restarts from entry 0 with X_cnt=0.
//   5 wr_en to entry 0 while busy -> emitted pattern unchanged; start with
//     num_runs=0 -> no X_valid, state stays IDLE.
//   6 reset asserted mid-RUN -> next cycle all outputs 0; restart without
//     reloading reproduces scenario 1 output.

Source files
------------

// File: rtl/pattern_generator_if.sv
// Bundle of the run-table write port, emission controls and emitted bit stream.
// Latency: none (wires only).
// Backpressure: none; the stream is push-only and the consumer must accept every X_valid bit.
//
// Ports (master = table loader / controller, slave = pattern_generator):
//   wr_en, wr_addr, wr_val, wr_len : run-table write port
//   num_runs, loop                 : pattern shape, sampled at start
//   start, abort                   : emission control pulses
//   X, X_valid, X_cnt              : emitted bit, its qualifier, emitted-bit count
//   busy, done                     : status (RUN / finished one-shot pattern)
interface pattern_generator_if #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic             wr_val;
    logic [LEN_W-1:0] wr_len;
    logic [IDX_W:0]   num_runs;
    logic             loop;
    logic             start;
    logic             abort;

    logic             X;
    logic             X_valid;
    logic [CNT_W-1:0] X_cnt;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_val, wr_len, num_runs, loop, start, abort,
        input  X, X_valid, X_cnt, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_val, wr_len, num_runs, loop, start, abort,
        output X, X_valid, X_cnt, busy, done
    );
endinterface

// File: rtl/pattern_generator.sv
// Run-length-encoded bit-stream source: replays a (value, length) run table one bit per clock.
// Latency: first bit appears on X one cycle after the edge that samples start.
// Backpressure: none; bits are emitted every cycle in RUN, abort is the only way to stop early.
//
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   pg (slave) : table write port, num_runs/loop/start/abort controls,
//                registered outputs X, X_valid, X_cnt, busy, done
module pattern_generator #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    pattern_generator_if.slave pg
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NUM_W = IDX_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [IDX_W-1:0] idx;        // entry currently on X
    logic [LEN_W-1:0] run_cnt;    // cycles left in the current entry after this one
    logic [NUM_W-1:0] num_q;      // active entry count latched at start
    logic             loop_q;

    logic             x_q;
    logic             x_valid_q;
    logic [CNT_W-1:0] x_cnt_q;
    logic             busy_q;
    logic             done_q;

    // Run table: deliberately not reset so a pattern survives reset/abort.
    logic             tab_val [DEPTH];
    logic [LEN_W-1:0] tab_len [DEPTH];

    // ------------------------------------------------------------------
    // Table write port: frozen while a pattern is being emitted so the
    // stream cannot change underneath the sequencer.
    // ------------------------------------------------------------------
    logic wr_ok;
    assign wr_ok = pg.wr_en && (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tab_val[pg.wr_addr] <= pg.wr_val;
            tab_len[pg.wr_addr] <= pg.wr_len;
        end
    end

    // ------------------------------------------------------------------
    // Start-side decode
    // ------------------------------------------------------------------
    logic             start_ok;
    logic             fwd0;
    logic             first_val;
    logic [LEN_W-1:0] first_len;
    logic [NUM_W-1:0] num_clamped;

    assign start_ok = pg.start && (pg.num_runs != '0) && (state != ST_RUN);

    // A write to entry 0 in the same cycle as start lands in the table at
    // the same edge the first bit is loaded, so forward it around the array.
    assign fwd0      = wr_ok && (pg.wr_addr == '0);
    assign first_val = fwd0 ? pg.wr_val : tab_val[0];
    assign first_len = fwd0 ? pg.wr_len : tab_len[0];

    // num_runs can encode more than DEPTH; never walk past the table.
    assign num_clamped = (pg.num_runs > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : pg.num_runs;

    // ------------------------------------------------------------------
    // Run-side decode
    // ------------------------------------------------------------------
    logic             last_entry;
    logic [IDX_W-1:0] next_idx;
    logic [CNT_W-1:0] cnt_sat;

    assign last_entry = (({1'b0, idx} + NUM_W'(1)) == num_q);

    // After the last entry a looping pattern wraps straight back to entry 0,
    // which keeps the stream gap-free across the wrap.
    assign next_idx   = last_entry ? '0 : (idx + IDX_W'(1));

    assign cnt_sat    = (x_cnt_q == '1) ? x_cnt_q : (x_cnt_q + CNT_W'(1));

    // ------------------------------------------------------------------
    // Sequencer and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            run_cnt   <= '0;
            num_q     <= '0;
            loop_q    <= 1'b0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            x_cnt_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (pg.abort) begin
            // Abort wins over start; the count is left for inspection.
            state     <= ST_IDLE;
            idx       <= '0;
            run_cnt   <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    // Every RUN cycle carries a valid bit, so count it here.
                    x_cnt_q <= cnt_sat;
                    if (run_cnt != '0) begin
                        run_cnt <= run_cnt - LEN_W'(1);
                    end else if (last_entry && !loop_q) begin
                        state     <= ST_DONE;
                        idx       <= '0;
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        idx     <= next_idx;
                        x_q     <= tab_val[next_idx];
                        run_cnt <= tab_len[next_idx];
                    end
                end
                default: begin
                    if (start_ok) begin
                        state     <= ST_RUN;
                        num_q     <= num_clamped;
                        loop_q    <= pg.loop;
                        idx       <= '0;
                        run_cnt   <= first_len;
                        x_q       <= first_val;
                        x_valid_q <= 1'b1;
                        x_cnt_q   <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end else if (state != ST_DONE) begin
                        // Parks the unused encoding in IDLE as well.
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign pg.X       = x_q;
    assign pg.X_valid = x_valid_q;
    assign pg.X_cnt   = x_cnt_q;
    assign pg.busy    = busy_q;
    assign pg.done    = done_q;
endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: directed scenarios plus randomized traffic against a queue-based model.
// The model expands the run table into a flat bit list at start and indexes it once per cycle.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_pattern_generator;
    localparam int DEPTH   = 8;
    localparam int LEN_W   = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam string S1   = "000011111111000011110000000011110000";

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pattern_generator_if #(.DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    pattern_generator #(.DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .pg    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit             m_val [DEPTH];
    int             m_len [DEPTH];
    bit             m_pat [$];
    int             m_pos  = 0;
    bit             m_run  = 1'b0;
    bit             m_done = 1'b0;
    bit             m_loop = 1'b0;
    int             m_cnt  = 0;

    initial forever begin
        @(posedge clk);
        if (bus.wr_en && !m_run) begin
            m_val[bus.wr_addr] = bus.wr_val;
            m_len[bus.wr_addr] = int'(bus.wr_len);
        end
        if (reset) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
        end else if (bus.abort) begin
            m_run  = 1'b0;
            m_done = 1'b0;
        end else if (m_run) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_pos++;
            if (m_pos >= m_pat.size()) begin
                if (m_loop) begin
                    m_pos = 0;
                end else begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (bus.start && bus.num_runs != 0) begin
            m_pat.delete();
            for (int e = 0; e < int'(bus.num_runs); e++)
                for (int k = 0; k <= m_len[e]; k++)
                    m_pat.push_back(m_val[e]);
            m_pos  = 0;
            m_loop = bus.loop;
            m_run  = 1'b1;
            m_done = 1'b0;
            m_cnt  = 0;
        end
    end

    function automatic string model_str();
        string s = "";
        for (int i = 0; i < m_pat.size(); i++) s = {s, m_pat[i] ? "1" : "0"};
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Compare process + capture of emitted bits
    // ------------------------------------------------------------------
    bit dut_bits [$];

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("X",       bus.X,       (m_run ? m_pat[m_pos] : 1'b0));
            chk("X_valid", bus.X_valid, m_run);
            chk("busy",    bus.busy,    m_run);
            chk("done",    bus.done,    m_done);
            chk("X_cnt",   bus.X_cnt,   m_cnt);
            if (bus.X_valid === 1'b1) dut_bits.push_back(bus.X);
        end
    end

    function automatic string bits_str(input int first, input int n);
        string s = "";
        for (int i = first; i < first + n && i < dut_bits.size(); i++)
            s = {s, dut_bits[i] ? "1" : "0"};
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input bit v, input int l);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[2:0];
        bus.wr_val  = v;
        bus.wr_len  = l[7:0];
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_start(input int n, input bit lp);
        bus.num_runs = n[3:0];
        bus.loop     = lp;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i = 0;
        while (bus.done !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        chk({name, "_done_in_time"}, bus.done, 1);
    endtask

    task automatic chk_idle_zero(input string name);
        chk({name, "_X"},       bus.X,       0);
        chk({name, "_X_valid"}, bus.X_valid, 0);
        chk({name, "_X_cnt"},   bus.X_cnt,   0);
        chk({name, "_busy"},    bus.busy,    0);
        chk({name, "_done"},    bus.done,    0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lens [7] = '{3, 7, 3, 3, 7, 3, 3};
        int pre;

        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_val   = 1'b0;
        bus.wr_len   = '0;
        bus.num_runs = '0;
        bus.loop     = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;

        step();
        chk_en = 1'b1;
        step();
        chk_idle_zero("reset");
        reset = 1'b0;

        for (int e = 0; e < 7; e++) write_entry(e, e[0], lens[e]);

        // 1: one-shot replay
        dut_bits.delete();
        do_start(7, 1'b0);
        chk("s1_first_valid", bus.X_valid, 1);
        chk("s1_first_cnt",   bus.X_cnt,   0);
        chk_str("s1_model_pattern", model_str(), S1);
        wait_done("s1", 100);
        chk_str("s1_bits", bits_str(0, dut_bits.size()), S1);
        chk("s1_cnt",  bus.X_cnt, 36);
        chk("s1_busy", bus.busy,  0);

        // 2/3: loop, gap-free wrap, then counter saturation
        dut_bits.delete();
        do_start(7, 1'b1);
        repeat (80) step();
        chk_str("s2_two_laps", bits_str(0, 72), {S1, S1});
        chk("s2_busy", bus.busy, 1);
        chk("s2_done", bus.done, 0);
        repeat (220) step();
        chk("s3_cnt_sat", bus.X_cnt, 255);
        do_abort();
        chk("s3_abort_valid", bus.X_valid, 0);
        chk("s3_abort_cnt",   bus.X_cnt,   255);

        // 4: abort at bit 10, then restart from entry 0
        do_start(7, 1'b0);
        repeat (10) step();
        chk("s4_pre_abort_cnt", bus.X_cnt, 10);
        do_abort();
        chk("s4_valid", bus.X_valid, 0);
        chk("s4_busy",  bus.busy,    0);
        chk("s4_done",  bus.done,    0);
        chk("s4_cnt",   bus.X_cnt,   10);
        dut_bits.delete();
        do_start(7, 1'b0);
        chk("s4_restart_cnt", bus.X_cnt, 0);
        chk("s4_restart_x",   bus.X,     0);
        wait_done("s4", 100);
        chk_str("s4_bits", bits_str(0, dut_bits.size()), S1);

        // write and start in the same cycle: new entry 0 is what gets emitted
        dut_bits.delete();
        bus.wr_en    = 1'b1;
        bus.wr_addr  = '0;
        bus.wr_val   = 1'b1;
        bus.wr_len   = 8'd1;
        bus.num_runs = 4'd1;
        bus.loop     = 1'b0;
        bus.start    = 1'b1;
        step();
        bus.wr_en    = 1'b0;
        bus.start    = 1'b0;
        chk("wrst_first_x", bus.X, 1);
        wait_done("wrst", 20);
        chk_str("wrst_bits", bits_str(0, dut_bits.size()), "11");
        chk("wrst_cnt", bus.X_cnt, 2);
        write_entry(0, 1'b0, 3);

        // 5: write while busy is dropped; start with zero runs is ignored
        dut_bits.delete();
        do_start(7, 1'b0);
        repeat (3) step();
        write_entry(0, 1'b1, 0);
        bus.start = 1'b1;          // start while RUN must not restart
        step();
        bus.start = 1'b0;
        wait_done("s5", 100);
        chk_str("s5_bits", bits_str(0, dut_bits.size()), S1);
        do_abort();
        dut_bits.delete();
        pre = bus.X_cnt;
        do_start(0, 1'b0);
        repeat (5) step();
        chk("s5_no_bits", dut_bits.size(), 0);
        chk("s5_busy",    bus.busy, 0);
        chk("s5_cnt",     bus.X_cnt, pre);

        // 6: reset mid-run keeps the table
        do_start(7, 1'b0);
        repeat (5) step();
        reset = 1'b1;
        step();
        chk_idle_zero("s6_reset");
        reset = 1'b0;
        dut_bits.delete();
        do_start(7, 1'b0);
        wait_done("s6", 100);
        chk_str("s6_bits", bits_str(0, dut_bits.size()), S1);

        // randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            bus.wr_en    = ($urandom % 4) == 0;
            bus.wr_addr  = 3'($urandom_range(0, DEPTH - 1));
            bus.wr_val   = 1'($urandom % 2);
            bus.wr_len   = 8'($urandom_range(0, 5));
            bus.num_runs = 4'($urandom_range(0, DEPTH));
            bus.loop     = 1'($urandom % 2);
            bus.start    = ($urandom % 16) == 0;
            bus.abort    = ($urandom % 64) == 0;
            reset        = ($urandom % 400) == 0;
            step();
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b0;
        step();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
